// File: rtl/instruction_fetcher.sv
// instruction_fetcher: front-end fetch stage. It issues one memory fetch at a
// time, predicts the next PC and buffers fetched words in a small queue whose
// head feeds the decoder.
// Optional feature: define FETCHER_BHT_EN to build a 2-bit branch history
// table for conditional-branch prediction. Without it, every conditional
// branch is predicted not-taken.
module instruction_fetcher #(
  parameter int IQ_DEPTH = 4,
  parameter int BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  input  logic [31:0] in_mem_inst,
  input  logic        in_mem_done,
  output logic [31:0] out_dec_inst,
  output logic [31:0] out_dec_pc,
  output logic        out_dec_jump_flag,
  output logic        out_dec_valid,
  input  logic        in_issue_stall,
  input  logic        in_rob_clear,
  input  logic [31:0] in_rob_newpc,
  input  logic        in_rob_br_valid,
  input  logic [31:0] in_rob_br_pc,
  input  logic        in_rob_br_taken
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t        state, state_nx;
  logic [31:0]   pc, pc_nx;
  logic          mem_req_nx;
  logic [31:0]   mem_addr_nx;
  logic          push;
  logic          pop;

  logic [31:0]   q_inst [IQ_DEPTH];
  logic [31:0]   q_pc   [IQ_DEPTH];
  logic          q_flag [IQ_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [6:0]    opcode;
  logic [31:0]   j_imm, b_imm;
  logic [31:0]   next_pc;
  logic          next_flag;
  logic          br_predict_taken;

  // Immediate decode of the returned word (only meaningful while in_mem_done)
  assign opcode = in_mem_inst[6:0];
  assign j_imm  = {{11{in_mem_inst[31]}}, in_mem_inst[31], in_mem_inst[19:12],
                   in_mem_inst[20], in_mem_inst[30:21], 1'b0};
  assign b_imm  = {{19{in_mem_inst[31]}}, in_mem_inst[31], in_mem_inst[7],
                   in_mem_inst[30:25], in_mem_inst[11:8], 1'b0};

`ifdef FETCHER_BHT_EN
  localparam int unsigned BHT_N = 2 ** BHT_BITS;

  logic [1:0]          bht [BHT_N];
  logic [BHT_BITS-1:0] bht_rd_idx;
  logic [BHT_BITS-1:0] bht_wr_idx;
  logic                unused_br;

  assign bht_rd_idx       = pc[BHT_BITS+1:2];
  assign bht_wr_idx       = in_rob_br_pc[BHT_BITS+1:2];
  assign br_predict_taken = bht[bht_rd_idx][1];
  assign unused_br        = ^{in_rob_br_pc[31:BHT_BITS+2], in_rob_br_pc[1:0]};

  // Saturating counter training from committed branch outcomes (also in clear cycles)
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (rdy && in_rob_br_valid) begin
      if (in_rob_br_taken && bht[bht_wr_idx] != 2'b11)
        bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'd1;
      else if (!in_rob_br_taken && bht[bht_wr_idx] != 2'b00)
        bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'd1;
    end
  end
`else
  logic unused_br;

  assign br_predict_taken = 1'b0;
  assign unused_br        = ^{in_rob_br_valid, in_rob_br_pc, in_rob_br_taken};
`endif

  // Next-PC prediction for the word being returned at the current pc
  always_comb begin
    next_pc   = pc + 32'd4;
    next_flag = 1'b0;
    if (opcode == OP_JAL) begin
      next_pc   = pc + j_imm;
      next_flag = 1'b1;
    end else if (opcode == OP_BRANCH && br_predict_taken) begin
      next_pc   = pc + b_imm;
      next_flag = 1'b1;
    end
  end

  // Fetch FSM next-state, request and pc update
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    mem_req_nx  = out_mem_req;
    mem_addr_nx = out_mem_addr;
    push        = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_rob_clear) begin
          pc_nx = in_rob_newpc;
        end else if (count < DEPTH_C) begin
          state_nx    = BUSY;
          mem_req_nx  = 1'b1;
          mem_addr_nx = pc;
        end
      end
      BUSY: begin
        if (in_rob_clear) begin
          // A completion in the clear cycle is dropped; otherwise wait it out
          pc_nx      = in_rob_newpc;
          mem_req_nx = 1'b0;
          state_nx   = in_mem_done ? IDLE : FLUSH;
        end else if (in_mem_done) begin
          push       = 1'b1;
          pc_nx      = next_pc;
          mem_req_nx = 1'b0;
          state_nx   = IDLE;
        end
      end
      FLUSH: begin
        if (in_rob_clear) pc_nx = in_rob_newpc;
        if (in_mem_done) state_nx = IDLE;
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
      end
    endcase
  end

  // FSM state, pc and memory request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= '0;
      out_mem_req  <= 1'b0;
      out_mem_addr <= '0;
    end else if (rdy) begin
      state        <= state_nx;
      pc           <= pc_nx;
      out_mem_req  <= mem_req_nx;
      out_mem_addr <= mem_addr_nx;
    end
  end

  assign pop = out_dec_valid & ~in_issue_stall & ~in_rob_clear;

  // Queue pointers and occupancy; a clear wins over any push or pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (in_rob_clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; contents past count are don't-care so no reset is needed
  always_ff @(posedge clk) begin
    if (rdy && push) begin
      q_inst[tail] <= in_mem_inst;
      q_pc[tail]   <= pc;
      q_flag[tail] <= next_flag;
    end
  end

  // Decoder view of the queue head, zeroed while empty
  always_comb begin
    out_dec_valid     = (count != '0);
    out_dec_inst      = '0;
    out_dec_pc        = '0;
    out_dec_jump_flag = 1'b0;
    if (out_dec_valid) begin
      out_dec_inst      = q_inst[head];
      out_dec_pc        = q_pc[head];
      out_dec_jump_flag = q_flag[head];
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized bench for instruction_fetcher against a transaction-level model
// (queue of fetched entries, outstanding-request flags, counter array).
module tb_instruction_fetcher;

  localparam int IQ_DEPTH = 4;
  localparam int BHT_BITS = 6;
  localparam int K_OTHER  = 0;
  localparam int K_JAL    = 1;
  localparam int K_BR     = 2;
`ifdef FETCHER_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        out_mem_req;
  logic [31:0] out_mem_addr;
  logic [31:0] in_mem_inst;
  logic        in_mem_done;
  logic [31:0] out_dec_inst, out_dec_pc;
  logic        out_dec_jump_flag, out_dec_valid;
  logic        in_issue_stall, in_rob_clear;
  logic [31:0] in_rob_newpc;
  logic        in_rob_br_valid;
  logic [31:0] in_rob_br_pc;
  logic        in_rob_br_taken;

  instruction_fetcher #(.IQ_DEPTH(IQ_DEPTH), .BHT_BITS(BHT_BITS)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_inst(in_mem_inst), .in_mem_done(in_mem_done),
    .out_dec_inst(out_dec_inst), .out_dec_pc(out_dec_pc),
    .out_dec_jump_flag(out_dec_jump_flag), .out_dec_valid(out_dec_valid),
    .in_issue_stall(in_issue_stall), .in_rob_clear(in_rob_clear),
    .in_rob_newpc(in_rob_newpc), .in_rob_br_valid(in_rob_br_valid),
    .in_rob_br_pc(in_rob_br_pc), .in_rob_br_taken(in_rob_br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flag;
  } entry_t;

  // Reference model state
  entry_t      m_q[$];
  logic [31:0] m_pc, m_addr;
  bit          m_req, m_stale;
  int          m_bht [64];

  // Memory responder state
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Program image: the plan's fixed words at their addresses, hashed mix elsewhere
  function automatic void gen(input logic [31:0] a, output int kind,
                              output logic [31:0] off, output logic [31:0] word);
    logic [31:0] h;
    logic [5:0]  o6;
    logic [2:0]  sel;
    h    = a * 32'h9E3779B1;
    h    = h ^ (h >> 15);
    o6   = h[15:10];
    sel  = h[31:29];
    off  = ({26'd0, o6} - 32'd32) << 2;
    kind = K_OTHER;
    word = {h[24:0], 7'b0010011};
    if (a == 32'h0) begin
      word = 32'h00100093; off = 32'd0;
    end else if (a == 32'h4) begin
      word = 32'h00200113; off = 32'd0;
    end else if (a == 32'h10) begin
      word = 32'h0080006F; kind = K_JAL; off = 32'd8;
    end else if (a == 32'h40) begin
      word = 32'hFE000EE3; kind = K_BR; off = 32'hFFFFFFFC;
    end else if (sel == 3'd0) begin
      kind = K_JAL;
      word = {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
    end else if (sel == 3'd1 || sel == 3'd2) begin
      kind = K_BR;
      word = {off[12], off[10:5], 5'd2, 5'd1, 3'b000, off[4:1], off[11], 7'b1100011};
    end else if (sel == 3'd3) begin
      word = 32'h000080E7;
    end
  endfunction

  task automatic compare_outputs();
    check("dec_valid", 32'(out_dec_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("dec_inst", out_dec_inst, m_q[0].inst);
      check("dec_pc", out_dec_pc, m_q[0].pc);
      check("dec_flag", 32'(out_dec_jump_flag), 32'(m_q[0].flag));
    end else begin
      check("dec_inst_empty", out_dec_inst, 32'h0);
      check("dec_pc_empty", out_dec_pc, 32'h0);
      check("dec_flag_empty", 32'(out_dec_jump_flag), 32'h0);
    end
    check("mem_req", 32'(out_mem_req), 32'(m_req));
    if (m_req) check("mem_addr", out_mem_addr, m_addr);
  endtask

  task automatic model_update(input bit stall, input bit clear, input logic [31:0] newpc,
                              input bit brv, input logic [31:0] brpc, input bit brt,
                              input bit rdy_v, input bit rst_v, input bit done);
    int          sz, kind, idx;
    logic [31:0] off, word;
    entry_t      e;
    if (!rst_v) begin
      m_q.delete();
      m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_stale = 1'b0;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      return;
    end
    if (!rdy_v) return;
    sz = m_q.size();
    if (clear) begin
      m_q.delete();
      m_pc = newpc;
      if (m_req) begin
        m_req   = 1'b0;
        m_stale = !done;
      end else if (m_stale && done) begin
        m_stale = 1'b0;
      end
    end else begin
      if (sz > 0 && !stall) void'(m_q.pop_front());
      if (m_req) begin
        if (done) begin
          gen(m_pc, kind, off, word);
          e.inst = word;
          e.pc   = m_pc;
          e.flag = 1'b0;
          idx    = int'((m_pc >> 2) % 32'd64);
          if (kind == K_JAL || (kind == K_BR && BHT_ON && m_bht[idx] >= 2)) e.flag = 1'b1;
          m_q.push_back(e);
          m_pc  = e.flag ? m_pc + off : m_pc + 32'd4;
          m_req = 1'b0;
        end
      end else if (m_stale) begin
        if (done) m_stale = 1'b0;
      end else if (sz < IQ_DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
    if (BHT_ON && brv) begin
      idx = int'((brpc >> 2) % 32'd64);
      if (brt && m_bht[idx] < 3) m_bht[idx]++;
      else if (!brt && m_bht[idx] > 0) m_bht[idx]--;
    end
  endtask

  // One cycle: check settled outputs, drive inputs, run the memory, advance the model
  task automatic step(input bit stall, input bit clear, input logic [31:0] newpc,
                      input bit brv, input logic [31:0] brpc, input bit brt,
                      input bit rdy_v, input bit rst_v);
    int          kind;
    logic [31:0] off, word;
    bit          done;
    @(negedge clk);
    compare_outputs();
    rst             = rst_v;
    rdy             = rdy_v;
    in_issue_stall  = stall;
    in_rob_clear    = clear;
    in_rob_newpc    = newpc;
    in_rob_br_valid = brv;
    in_rob_br_pc    = brpc;
    in_rob_br_taken = brt;
    in_mem_done     = 1'b0;
    in_mem_inst     = $urandom();
    done            = 1'b0;
    if (!rst_v) begin
      mem_pend = 1'b0;
    end else if (rdy_v) begin
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          gen(mem_a, kind, off, word);
          in_mem_done = 1'b1;
          in_mem_inst = word;
          mem_pend    = 1'b0;
          done        = 1'b1;
        end else begin
          mem_cnt--;
        end
      end else if (out_mem_req) begin
        mem_pend = 1'b1;
        mem_a    = out_mem_addr;
        mem_cnt  = int'($urandom_range(0, 2));
      end
    end
    model_update(stall, clear, newpc, brv, brpc, brt, rdy_v, rst_v, done);
  endtask

  task automatic run(input int n, input bit stall);
    for (int i = 0; i < n; i++) step(stall, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !m_req; i++) run(1, 1'b0);
  endtask

  // Step until a request to some address other than 'a' is pending in the model
  task automatic wait_req_not(input logic [31:0] a, input int budget);
    for (int i = 0; i < budget && !(m_req && m_addr != a); i++) run(1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; in_mem_done = 1'b0; in_mem_inst = '0;
    in_issue_stall = 1'b0; in_rob_clear = 1'b0; in_rob_newpc = '0;
    in_rob_br_valid = 1'b0; in_rob_br_pc = '0; in_rob_br_taken = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; mem_a = '0;

    // Reset, then sequential fetch from 0
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    run(30, 1'b0);

    // Queue fills while stalled, then drains
    run(30, 1'b1);
    run(12, 1'b0);

    // Clear while a fetch is outstanding
    wait_req(20);
    step(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_req(20);
    @(posedge clk); #1;
    check("redirect_addr", out_mem_addr, 32'h200);
    run(10, 1'b0);

    // JAL at 0x10 redirects the next fetch to 0x18
    step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_req_not(32'h10, 30);
    @(posedge clk); #1;
    check("jal_target", out_mem_addr, 32'h18);
    run(6, 1'b0);

    // Train the counter for the branch at 0x40, then refetch it
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_req_not(32'h40, 30);
    @(posedge clk); #1;
    check("branch_target", out_mem_addr, BHT_ON ? 32'h3C : 32'h44);
    run(6, 1'b0);

    // Freeze mid-fetch
    wait_req(20);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    run(20, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 29) == 0,
           32'($urandom_range(0, 63)) << 2,
           $urandom_range(0, 4) == 0,
           32'($urandom_range(0, 127)) << 2,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 299) != 0);
    end
    run(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
